// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory access controller holding the MAR/MDR pair and running the
// IDLE -> ACCESS -> DONE -> RELEASE handshake towards a simple request/ready memory.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that has not seen MemReady
// after TIMEOUT_CYCLES cycles. An aborted access sets the sticky Err flag and completes with
// an R pulse. An aborted read loads all-ones into MDR. Without the macro, ACCESS waits
// indefinitely and Err is tied to 0.
//
// Ports:
//   Clk, Reset_n        clock; asynchronous active-low reset
//   Bus                 datapath bus, source for MAR/MDR loads
//   LD_MAR, LD_MDR      load strobes (LD_MDR ignored when MIO_EN=1)
//   MIO_EN, R_W         memory access request and direction (1=write, 0=read)
//   MemReq, MemWe       memory request and write enable
//   MemAddr, MemWData   MAR and MDR, driven straight to memory
//   MemRData, MemReady  memory read data and completion strobe
//   MDR_Out             MDR contents for the bus multiplexer
//   R                   one-cycle access-complete pulse
//   Err                 sticky timeout flag
module mem_access_ctrl #(
  parameter int unsigned N              = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [N-1:0] Bus,
  input  logic         LD_MAR,
  input  logic         LD_MDR,
  input  logic         MIO_EN,
  input  logic         R_W,
  output logic         MemReq,
  output logic         MemWe,
  output logic [N-1:0] MemAddr,
  output logic [N-1:0] MemWData,
  input  logic [N-1:0] MemRData,
  input  logic         MemReady,
  output logic [N-1:0] MDR_Out,
  output logic         R,
  output logic         Err
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StRelease} state_e;

  state_e       state_q;
  logic [N-1:0] mar_q;
  logic [N-1:0] mdr_q;
  logic         req_q;
  logic         we_q;
  logic         r_q;

`ifdef MEM_TIMEOUT_EN
  // Counter runs 0 .. TIMEOUT_CYCLES-1; reaching the last value without MemReady aborts.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (LD_MAR) mar_q <= Bus;
          if (MIO_EN) begin
            state_q <= StAccess;
            req_q   <= 1'b1;
            we_q    <= R_W;
            cnt_q   <= '0;
          end else if (LD_MDR) begin
            mdr_q <= Bus;
          end
        end
        StAccess: begin
          // MemReady on the same edge takes priority over the timeout.
          if (MemReady) begin
            if (!we_q) mdr_q <= MemRData;
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
          end else if (cnt_q == CntLast) begin
            if (!we_q) mdr_q <= '1;
            err_q   <= 1'b1;
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          r_q     <= 1'b0;
          state_q <= MIO_EN ? StRelease : StIdle;
        end
        StRelease: begin
          if (!MIO_EN) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Err = err_q;
`else
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (LD_MAR) mar_q <= Bus;
          if (MIO_EN) begin
            state_q <= StAccess;
            req_q   <= 1'b1;
            we_q    <= R_W;
          end else if (LD_MDR) begin
            mdr_q <= Bus;
          end
        end
        StAccess: begin
          if (MemReady) begin
            if (!we_q) mdr_q <= MemRData;
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
          end
        end
        StDone: begin
          r_q     <= 1'b0;
          state_q <= MIO_EN ? StRelease : StIdle;
        end
        StRelease: begin
          if (!MIO_EN) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Timeout parameter has no effect in this build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);

  assign Err = 1'b0;
`endif

  assign MemReq   = req_q;
  assign MemWe    = we_q;
  assign MemAddr  = mar_q;
  assign MemWData = mdr_q;
  assign MDR_Out  = mdr_q;
  assign R        = r_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a per-cycle vector table covering loads, write and
// read transactions, RELEASE hold and ignored inputs, plus hand-written sequences for
// asynchronous reset mid-access and (with MEM_TIMEOUT_EN) the timeout abort.
module tb_mem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Bus;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W;
  logic        MemReq, MemWe;
  logic [15:0] MemAddr, MemWData, MemRData, MDR_Out;
  logic        MemReady, R, Err;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(
    .N             (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Bus     (Bus),
    .LD_MAR  (LD_MAR),
    .LD_MDR  (LD_MDR),
    .MIO_EN  (MIO_EN),
    .R_W     (R_W),
    .MemReq  (MemReq),
    .MemWe   (MemWe),
    .MemAddr (MemAddr),
    .MemWData(MemWData),
    .MemRData(MemRData),
    .MemReady(MemReady),
    .MDR_Out (MDR_Out),
    .R       (R),
    .Err     (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ld_mar;
    logic        ld_mdr;
    logic [15:0] bus;
    logic        mio;
    logic        rw;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_mdr;
    logic        e_r;
  } vec_t;

  localparam int NumVec = 21;
  vec_t vecs [NumVec];

  function automatic vec_t mk(input logic ld_mar, input logic ld_mdr, input logic [15:0] bus,
                              input logic mio, input logic rw, input logic rdy,
                              input logic [15:0] rdata, input logic e_req, input logic e_we,
                              input logic [15:0] e_addr, input logic [15:0] e_mdr,
                              input logic e_r);
    vec_t v;
    v.ld_mar = ld_mar; v.ld_mdr = ld_mdr; v.bus = bus; v.mio = mio; v.rw = rw;
    v.rdy = rdy; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
    v.e_mdr = e_mdr; v.e_r = e_r;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    LD_MAR = v.ld_mar; LD_MDR = v.ld_mdr; Bus = v.bus; MIO_EN = v.mio; R_W = v.rw;
    MemReady = v.rdy; MemRData = v.rdata;
  endtask

  task automatic idle_inputs();
    LD_MAR = 0; LD_MDR = 0; Bus = '0; MIO_EN = 0; R_W = 0; MemReady = 0; MemRData = '0;
  endtask

  // Apply inputs, clock once, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //              mar mdr bus      mio rw rdy rdata    req we addr     mdr      r
    // Write transaction: MemReady on the 3rd ACCESS cycle, LD_* ignored in ACCESS.
    vecs[0]  = mk(1, 0, 16'h3000, 0, 0, 0, 16'h0000, 0, 0, 16'h3000, 16'h0000, 0);
    vecs[1]  = mk(0, 1, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[2]  = mk(0, 1, 16'h0000, 1, 1, 0, 16'h0000, 1, 1, 16'h3000, 16'hBEEF, 0);
    vecs[3]  = mk(1, 0, 16'hFFFF, 1, 0, 0, 16'h0000, 1, 1, 16'h3000, 16'hBEEF, 0);
    vecs[4]  = mk(0, 1, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h3000, 16'hBEEF, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 1, 1, 16'h5555, 0, 0, 16'h3000, 16'hBEEF, 1);
    // MIO_EN held 5 cycles after R: RELEASE, no retrigger, loads ignored.
    vecs[6]  = mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[7]  = mk(1, 1, 16'h1234, 1, 0, 1, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[8]  = mk(1, 1, 16'h1234, 1, 0, 1, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[9]  = mk(1, 1, 16'h1234, 1, 0, 0, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[10] = mk(1, 1, 16'h1234, 1, 0, 0, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    vecs[11] = mk(1, 0, 16'h7777, 0, 0, 0, 16'h0000, 0, 0, 16'h3000, 16'hBEEF, 0);
    // Both loads in one IDLE cycle, then a minimum-latency read.
    vecs[12] = mk(1, 1, 16'h0042, 0, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h0042, 0);
    vecs[13] = mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0042, 16'h0042, 0);
    vecs[14] = mk(0, 0, 16'h0000, 1, 0, 1, 16'h1234, 0, 0, 16'h0042, 16'h1234, 1);
    vecs[15] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'h1234, 0);
    // MemReady in IDLE is ignored.
    vecs[16] = mk(0, 0, 16'h0000, 0, 0, 1, 16'h9999, 0, 0, 16'h0042, 16'h1234, 0);
    // MIO_EN dropped during ACCESS: the read still completes.
    vecs[17] = mk(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0042, 16'h1234, 0);
    vecs[18] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0042, 16'h1234, 0);
    vecs[19] = mk(0, 0, 16'h0000, 0, 0, 1, 16'hABCD, 0, 0, 16'h0042, 16'hABCD, 1);
    vecs[20] = mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0042, 16'hABCD, 0);

    Reset_n = 1'b0;
    idle_inputs();
    #12;
    check("rst MemReq", {15'b0, MemReq}, 16'h0);
    check("rst MemWe", {15'b0, MemWe}, 16'h0);
    check("rst MemAddr", MemAddr, 16'h0);
    check("rst MDR_Out", MDR_Out, 16'h0);
    check("rst R", {15'b0, R}, 16'h0);
    check("rst Err", {15'b0, Err}, 16'h0);
    Reset_n = 1'b1;
    #1;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("v%0d MemReq", i), {15'b0, MemReq}, {15'b0, vecs[i].e_req});
      check($sformatf("v%0d MemWe", i), {15'b0, MemWe}, {15'b0, vecs[i].e_we});
      check($sformatf("v%0d MemAddr", i), MemAddr, vecs[i].e_addr);
      check($sformatf("v%0d MDR_Out", i), MDR_Out, vecs[i].e_mdr);
      check($sformatf("v%0d MemWData", i), MemWData, vecs[i].e_mdr);
      check($sformatf("v%0d R", i), {15'b0, R}, {15'b0, vecs[i].e_r});
      check($sformatf("v%0d Err", i), {15'b0, Err}, 16'h0);
    end

    // Asynchronous reset in the middle of an access.
    idle_inputs();
    MIO_EN = 1;
    step();
    check("pre-rst MemReq", {15'b0, MemReq}, 16'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async MemReq", {15'b0, MemReq}, 16'h0);
    check("async R", {15'b0, R}, 16'h0);
    check("async MDR_Out", MDR_Out, 16'h0);
    check("async MemAddr", MemAddr, 16'h0);
    MIO_EN = 0;
    MemReady = 1;
    #3;
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post-rst%0d R", i), {15'b0, R}, 16'h0);
      check($sformatf("post-rst%0d MemReq", i), {15'b0, MemReq}, 16'h0);
    end

`ifdef MEM_TIMEOUT_EN
    // Read that never sees MemReady: aborted after 4 ACCESS cycles.
    idle_inputs();
    MIO_EN = 1;
    step();
    MIO_EN = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("to%0d MemReq", i), {15'b0, MemReq}, 16'h1);
      check($sformatf("to%0d R", i), {15'b0, R}, 16'h0);
    end
    step();
    check("to R", {15'b0, R}, 16'h1);
    check("to MDR_Out", MDR_Out, 16'hFFFF);
    check("to Err", {15'b0, Err}, 16'h1);
    step();
    check("to Err sticky", {15'b0, Err}, 16'h1);
    check("to R low", {15'b0, R}, 16'h0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("to Err rst", {15'b0, Err}, 16'h0);
    Reset_n = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
